// File: rtl/scan_addr_gen.sv
// scan_addr_gen: read/write address generator for a KxK sliding-window scan
// Ports:
//   clk, n_reset       single clock, asynchronous active-low reset
//   width, length      image columns/rows, sampled on load_initial
//   initial_addr_r/_w  read/write bases, sampled on load_initial
//   mode               0 serpentine, 1 raster, sampled on load_initial
//   load_initial       level, loads configuration (wins over start_move)
//   start_move         level, one window move per cycle while scanning
//   addr_r, addr_w     current window anchor read address / output write address
//   direction          next move: 01 right, 10 left, 11 row advance, 00 raster return
//   move_done          one-cycle pulse after each move
//   load_done          one-cycle pulse after each load
//   all_done           level, scan complete until next load
module scan_addr_gen #(
    parameter int ADDR_W = 16,
    parameter int DIM_W  = 12,
    parameter int K      = 3
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic [DIM_W-1:0]  width,
    input  logic [DIM_W-1:0]  length,
    input  logic [ADDR_W-1:0] initial_addr_r,
    input  logic [ADDR_W-1:0] initial_addr_w,
    input  logic              mode,
    input  logic              load_initial,
    input  logic              start_move,
    output logic [ADDR_W-1:0] addr_r,
    output logic [ADDR_W-1:0] addr_w,
    output logic [1:0]        direction,
    output logic              move_done,
    output logic              load_done,
    output logic              all_done
);
    localparam logic [1:0] IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2;
    logic [1:0]        state;
    logic [DIM_W-1:0]  w, cols, rows, col, row;
    logic [DIM_W-1:0]  cols_in, rows_in, ncol, nrow, last_col;
    logic [ADDR_W-1:0] nr, nw;
    logic [1:0]        ndir;
    logic              md, ok, last;
    always_comb begin
        cols_in  = width - DIM_W'(K - 1);
        rows_in  = length - DIM_W'(K - 1);
        ok       = width >= DIM_W'(K) && length >= DIM_W'(K) && !(width == DIM_W'(K) && length == DIM_W'(K));
        ncol     = direction == 2'b01 ? col + DIM_W'(1) :
                   direction == 2'b10 ? col - DIM_W'(1) :
                   direction == 2'b11 ? col : '0;
        nrow     = direction[1] ~^ direction[0] ? row + DIM_W'(1) : row;
        nr       = direction == 2'b01 ? addr_r + ADDR_W'(1) :
                   direction == 2'b10 ? addr_r - ADDR_W'(1) :
                   direction == 2'b11 ? addr_r + ADDR_W'(w) : addr_r + ADDR_W'(K);
        // a raster return lands on column 0 of the next row, i.e. one output pixel further
        nw       = direction == 2'b10 ? addr_w - ADDR_W'(1) :
                   direction == 2'b11 ? addr_w + ADDR_W'(cols) : addr_w + ADDR_W'(1);
        // serpentine with an even row count finishes its last row heading left, at column 0
        last_col = (!md && !rows[0]) ? '0 : cols - DIM_W'(1);
        last     = nrow == rows - DIM_W'(1) && ncol == last_col;
        // odd rows of a serpentine scan travel left
        ndir     = cols == DIM_W'(1) ? 2'b11 :
                   md ? (ncol == cols - DIM_W'(1) ? 2'b00 : 2'b01) :
                   nrow[0] ? (ncol == '0 ? 2'b11 : 2'b10) :
                   (ncol == cols - DIM_W'(1) ? 2'b11 : 2'b01);
    end
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state     <= IDLE;
            w         <= '0;
            cols      <= '0;
            rows      <= '0;
            col       <= '0;
            row       <= '0;
            md        <= 1'b0;
            addr_r    <= '0;
            addr_w    <= '0;
            direction <= 2'b01;
            move_done <= 1'b0;
            load_done <= 1'b0;
            all_done  <= 1'b0;
        end else begin
            move_done <= 1'b0;
            load_done <= 1'b0;
            if (load_initial) begin
                w         <= width;
                cols      <= cols_in;
                rows      <= rows_in;
                md        <= mode;
                col       <= '0;
                row       <= '0;
                addr_r    <= initial_addr_r;
                addr_w    <= initial_addr_w;
                direction <= (ok && cols_in == DIM_W'(1)) ? 2'b11 : 2'b01;
                load_done <= 1'b1;
                all_done  <= !ok;
                state     <= ok ? SCAN : DONE;
            end else if (start_move && state == SCAN) begin
                col       <= ncol;
                row       <= nrow;
                addr_r    <= nr;
                addr_w    <= nw;
                direction <= ndir;
                move_done <= 1'b1;
                if (last) begin
                    all_done <= 1'b1;
                    state    <= DONE;
                end
            end
        end
    end
endmodule

// File: tb/tb_scan_addr_gen.sv
// tb_scan_addr_gen: scan_addr_gen checked against a position-list reference model
module tb_scan_addr_gen;
    logic        clk = 1'b0;
    logic        n_reset = 1'b1;
    logic [11:0] width = '0, length = '0;
    logic [15:0] init_r = '0, init_w = '0;
    logic        mode = 1'b0, load = 1'b0, start = 1'b0;
    logic [15:0] ar, aw;
    logic [7:0]  ar8, aw8;
    logic [1:0]  dir, dir8;
    logic        mdone, ldone, adone, mdone8, ldone8, adone8;
    int          vec = 0, bad = 0;

    scan_addr_gen u0 (
        .clk(clk), .n_reset(n_reset), .width(width), .length(length),
        .initial_addr_r(init_r), .initial_addr_w(init_w), .mode(mode),
        .load_initial(load), .start_move(start), .addr_r(ar), .addr_w(aw),
        .direction(dir), .move_done(mdone), .load_done(ldone), .all_done(adone)
    );

    scan_addr_gen #(.ADDR_W(8)) u8 (
        .clk(clk), .n_reset(n_reset), .width(width), .length(length),
        .initial_addr_r(init_r[7:0]), .initial_addr_w(init_w[7:0]), .mode(mode),
        .load_initial(load), .start_move(start), .addr_r(ar8), .addr_w(aw8),
        .direction(dir8), .move_done(mdone8), .load_done(ldone8), .all_done(adone8)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // direction implied by stepping from one window position to the next
    function automatic logic [31:0] step_dir(input int c0, r0, c1, r1);
        return r1 == r0 ? (c1 == c0 + 1 ? 32'd1 : 32'd2) : (c1 == c0 ? 32'd3 : 32'd0);
    endfunction

    task automatic run_scan(input bit m, input int wd, ln, input logic [31:0] br, bw,
                            input bit both, input bit b8);
        int pc[$], pr[$];
        int cols, rows, nm;
        bit degen;
        logic [31:0] mask, er, ew;
        cols  = wd - 2;
        rows  = ln - 2;
        degen = wd < 3 || ln < 3 || (cols == 1 && rows == 1);
        mask  = b8 ? 32'hff : 32'hffff;
        if (degen) begin
            pc.push_back(0);
            pr.push_back(0);
        end else begin
            for (int r = 0; r < rows; r++)
                for (int i = 0; i < cols; i++) begin
                    pc.push_back((!m && r[0]) ? cols - 1 - i : i);
                    pr.push_back(r);
                end
        end
        nm = pc.size() - 1;
        @(negedge clk);
        width = 12'(wd); length = 12'(ln); mode = m;
        init_r = br[15:0]; init_w = bw[15:0];
        load = 1'b1; start = both;
        @(negedge clk);
        load = 1'b0; start = 1'b1;
        chk("load_addr_r", b8 ? {24'h0, ar8} : {16'h0, ar}, br & mask);
        chk("load_addr_w", b8 ? {24'h0, aw8} : {16'h0, aw}, bw & mask);
        chk("load_done", {31'h0, ldone}, 32'd1);
        chk("load_no_move_done", {31'h0, mdone}, 32'd0);
        chk("load_all_done", {31'h0, adone}, {31'h0, degen});
        chk("load_dir", {30'h0, dir}, degen ? 32'd1 : step_dir(pc[0], pr[0], pc[1], pr[1]));
        for (int i = 1; i <= nm; i++) begin
            @(negedge clk);
            er = (br + 32'(pr[i] * wd + pc[i])) & mask;
            ew = (bw + 32'(pr[i] * cols + pc[i])) & mask;
            chk("move_addr_r", b8 ? {24'h0, ar8} : {16'h0, ar}, er);
            chk("move_addr_w", b8 ? {24'h0, aw8} : {16'h0, aw}, ew);
            chk("move_done", {31'h0, mdone}, 32'd1);
            chk("move_load_done", {31'h0, ldone}, 32'd0);
            chk("move_all_done", {31'h0, adone}, {31'h0, i == nm});
            if (i < nm) chk("move_dir", {30'h0, dir}, step_dir(pc[i], pr[i], pc[i+1], pr[i+1]));
        end
        er = (br + 32'(pr[nm] * wd + pc[nm])) & mask;
        repeat (3) begin
            @(negedge clk);
            chk("done_hold_r", b8 ? {24'h0, ar8} : {16'h0, ar}, er);
            chk("done_no_move", {31'h0, mdone}, 32'd0);
            chk("done_level", {31'h0, adone}, 32'd1);
        end
        start = 1'b0;
    endtask

    initial begin
        #3 n_reset = 1'b0;
        #1;
        chk("rst_addr_r", {16'h0, ar}, 32'd0);
        chk("rst_dir", {30'h0, dir}, 32'd1);
        chk("rst_flags", {29'h0, mdone, ldone, adone}, 32'd0);
        @(negedge clk);
        n_reset = 1'b1;
        start = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_ignore_r", {16'h0, ar}, 32'd0);
        chk("idle_no_move", {31'h0, mdone}, 32'd0);
        start = 1'b0;

        run_scan(0, 5, 5, 100, 0, 0, 0);
        run_scan(1, 5, 5, 100, 0, 0, 0);
        run_scan(0, 5, 5, 300, 40, 1, 0);
        run_scan(1, 2, 5, 77, 9, 0, 0);
        run_scan(0, 3, 3, 12, 34, 0, 0);
        run_scan(1, 3, 5, 500, 7, 0, 0);
        run_scan(0, 3, 6, 65530, 65534, 0, 0);
        run_scan(1, 5, 3, 254, 0, 0, 1);
        for (int t = 0; t < 14; t++)
            run_scan(1'($urandom_range(0, 1)), int'($urandom_range(2, 8)), int'($urandom_range(2, 8)),
                     32'($urandom_range(0, 65535)), 32'($urandom_range(0, 65535)),
                     1'($urandom_range(0, 1)), 1'b0);

        @(negedge clk);
        width = 12'd5; length = 12'd5; mode = 1'b0; init_r = 16'd100; init_w = 16'd0; load = 1'b1;
        @(negedge clk);
        load = 1'b0; start = 1'b1;
        repeat (4) @(negedge clk);
        chk("pre_rst_r", {16'h0, ar}, 32'd106);
        @(posedge clk);
        #2 n_reset = 1'b0;
        #1;
        chk("async_rst_r", {16'h0, ar}, 32'd0);
        chk("async_rst_w", {16'h0, aw}, 32'd0);
        chk("async_rst_dir", {30'h0, dir}, 32'd1);
        chk("async_rst_flags", {29'h0, mdone, ldone, adone}, 32'd0);
        @(negedge clk);
        n_reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_hold_r", {16'h0, ar}, 32'd0);
            chk("post_rst_no_move", {31'h0, mdone}, 32'd0);
        end
        start = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule

// File: doc/scan_addr_gen.md
SCAN_ADDR_GEN -- requirements
Module: scan_addr_gen

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, read/write address width.
REQ-002 SHALL have parameter DIM_W, default 12, image dimension width.
REQ-003 SHALL have parameter K, default 3, kernel size; valid window positions per row = width-K+1, rows = length-K+1.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port n_reset  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port width  in  DIM_W  image columns, sampled only on load.
REQ-007 SHALL have port length  in  DIM_W  image rows, sampled only on load.
REQ-008 SHALL have port initial_addr_r  in  ADDR_W  read base (first window anchor), sampled on load.
REQ-009 SHALL have port initial_addr_w  in  ADDR_W  write base (first output pixel), sampled on load.
REQ-010 SHALL have port mode  in  1  scan order, sampled on load: 0 serpentine, 1 raster.
REQ-011 SHALL have port load_initial  in  1  level; load configuration.
REQ-012 SHALL have port start_move  in  1  level; one move per cycle while high.
REQ-013 SHALL have port addr_r  out  ADDR_W  current window anchor read address.
REQ-014 SHALL have port addr_w  out  ADDR_W  current output write address.
REQ-015 SHALL have port direction  out  2  next move: 01 right, 10 left, 11 row advance (+width, same column), 00 raster return to next row start.
REQ-016 SHALL have port move_done, load_done  out  1 each  single-cycle pulses.
REQ-017 SHALL have port all_done  out  1  level; scan complete.

Function
REQ-018 SHALL implement states IDLE (no config), SCAN, DONE; IDLE->SCAN or DONE on load; SCAN->DONE on final move; any state->load on load_initial.
REQ-019 On edge with load_initial=1: latch width, length, mode, bases; addr_r=initial_addr_r, addr_w=initial_addr_w, col=row=0, direction=01 (11 if width-K+1==1 and rows>1, 00 never on single column); load_done high next cycle for one cycle.
REQ-020 load_initial SHALL have priority over simultaneous start_move; no move, no move_done.
REQ-021 On edge with start_move=1 in SCAN: addr_r/addr_w/direction update on that edge; move_done high the following cycle for one cycle; held start_move yields one move per cycle.
REQ-022 Serpentine: right moves addr_r+1, left moves addr_r-1, row advance addr_r+width; direction flips right/left after each row advance.
REQ-023 Raster: right moves addr_r+1; return moves addr_r + width - (width-K); direction always 01 or 00.
REQ-024 addr_w SHALL always equal initial_addr_w + row*(width-K+1) + col (raster output layout, also in serpentine: +1 right, -1 left, +(width-K+1) on row advance/return adjusted to target column).
REQ-025 Address arithmetic SHALL wrap modulo 2^ADDR_W; counters DIM_W bits.
REQ-026 all_done SHALL rise on the edge that reaches the last position (row=length-K, last column of that row) and hold until next load; direction after final move = 11 (serpentine) or 00 (raster), don't-care.
REQ-027 start_move in IDLE or DONE SHALL be ignored: outputs hold, no move_done.
REQ-028 width<K or length<K on load SHALL enter DONE directly: all_done=1 with load_done pulse, addresses = bases.
REQ-029 width==K and length==K SHALL enter DONE on load (single position).

Reset
REQ-030 n_reset low SHALL immediately force addr_r=0, addr_w=0, direction=01, move_done=load_done=all_done=0, state IDLE, counters 0, regardless of clock, including mid-scan.
REQ-031 After reset release, start_move SHALL be ignored until a load.

Verification
REQ-032 Serpentine, width=length=5, K=3, bases 100/0, load then start_move held: addr_r 101,102,107,106,105,110,111,112; addr_w 1,2,5,4,3,6,7,8; direction after 102 = 11, after 107 = 10, after 110 = 01; all_done=1 after 8th move.
REQ-033 Raster, same config: addr_r 101,102,105,106,107,110,111,112; direction=00 at 102 and 107; addr_w 1..8; all_done after 8th move.
REQ-034 load_initial and start_move both high one edge: addr_r=base, load_done pulse, no move_done; next start_move edge -> base+1.
REQ-035 Load width=2, length=5: all_done=1 with load_done; three start_move cycles -> addr_r stays base, move_done never asserted.
REQ-036 Serpentine 5x5 after 4 moves, drop n_reset asynchronously between edges: outputs 0/01 immediately; start_move held after release -> no change until load.
REQ-037 ADDR_W=8, raster, width=5, length=3, base_r=254: addr_r 254,255,0 then all_done=1.
